// File: rtl/food_placer_pkg.sv
// Shared constants and types for the food placement path.
package food_placer_pkg;

    localparam int unsigned COORD_W      = 10;
    localparam int unsigned MAX_SEGMENTS = 32;
    localparam int unsigned IDX_W        = 5;
    localparam int unsigned MAX_RETRY    = 15;

    // Grid lattice used by the random generator and the VGA draw logic: pixel = 25*k + 2.
    localparam int unsigned CELL_PITCH   = 25;
    localparam int unsigned CELL_OFFSET  = 2;

    // Largest legal food pixel coordinates inside the playfield.
    localparam int unsigned X_LIMIT      = 577;
    localparam int unsigned Y_LIMIT      = 452;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_SCAN   = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

endpackage

// File: rtl/food_placer_seg_scanner.sv
// Walks the snake body store and compares each returned segment with the candidate.
module food_placer_seg_scanner
    import food_placer_pkg::*;
#(
    parameter int unsigned MAX_SEGMENTS = food_placer_pkg::MAX_SEGMENTS,
    parameter int unsigned IDX_W        = food_placer_pkg::IDX_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               restart,
    input  logic               scan,
    input  logic [IDX_W:0]     snake_len,
    input  logic [COORD_W-1:0] cand_x,
    input  logic [COORD_W-1:0] cand_y,
    input  logic [COORD_W-1:0] seg_x,
    input  logic [COORD_W-1:0] seg_y,
    output logic [IDX_W-1:0]   seg_idx,
    output logic               empty_c,
    output logic               last_c,
    output logic               match_c
);

    localparam int unsigned LEN_W = IDX_W + 1;

    logic [LEN_W-1:0] eff_len;
    logic             cmp_valid;

    // Clamp the reported length to the store capacity and derive scan flags.
    always_comb begin
        eff_len = snake_len;
        if (snake_len > LEN_W'(MAX_SEGMENTS)) begin
            eff_len = LEN_W'(MAX_SEGMENTS);
        end
        empty_c = (eff_len == '0);
        last_c  = ({1'b0, seg_idx} == (eff_len - LEN_W'(1)));
        match_c = cmp_valid && (seg_x == cand_x) && (seg_y == cand_y);
    end

    // Index counter; read data is compared one cycle after its index was issued.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_idx   <= '0;
            cmp_valid <= 1'b0;
        end else begin
            cmp_valid <= scan;
            if (restart) begin
                seg_idx <= '0;
            end else if (scan && !last_c) begin
                seg_idx <= seg_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/food_placer.sv
// Food placement FSM: samples random candidates, rejects collisions, detects eating.
module food_placer
    import food_placer_pkg::*;
#(
    parameter int unsigned MAX_SEGMENTS = food_placer_pkg::MAX_SEGMENTS,
    parameter int unsigned IDX_W        = food_placer_pkg::IDX_W,
    parameter int unsigned MAX_RETRY    = food_placer_pkg::MAX_RETRY,
    parameter int unsigned X_LIMIT      = food_placer_pkg::X_LIMIT,
    parameter int unsigned Y_LIMIT      = food_placer_pkg::Y_LIMIT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               place_req,
    input  logic [9:0]         rand_x,
    input  logic [9:0]         rand_y,
    input  logic [IDX_W:0]     snake_len,
    output logic [IDX_W-1:0]   seg_idx,
    input  logic [9:0]         seg_x,
    input  logic [9:0]         seg_y,
    input  logic [9:0]         head_x,
    input  logic [9:0]         head_y,
    input  logic               head_strobe,
    output logic [9:0]         food_x,
    output logic [9:0]         food_y,
    output logic               food_valid,
    output logic               busy,
    output logic               place_done,
    output logic               place_fail,
    output logic               eaten
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    state_t             state, state_nxt;
    logic [RETRY_W-1:0] retry_cnt, retry_nxt;
    logic [9:0]         cand_x, cand_y, cand_x_nxt, cand_y_nxt;
    logic [9:0]         food_x_nxt, food_y_nxt;
    logic               food_valid_nxt, busy_nxt, done_nxt, fail_nxt, eaten_nxt;

    logic empty_c, last_c, match_c;
    logic eat_c, start_c, oob_c, reject_c, give_up_c, commit_c;

    food_placer_seg_scanner #(
        .MAX_SEGMENTS (MAX_SEGMENTS),
        .IDX_W        (IDX_W)
    ) u_scanner (
        .clock     (clock),
        .reset_n   (reset_n),
        .restart   (state == ST_SAMPLE),
        .scan      (state == ST_SCAN),
        .snake_len (snake_len),
        .cand_x    (cand_x),
        .cand_y    (cand_y),
        .seg_x     (seg_x),
        .seg_y     (seg_y),
        .seg_idx   (seg_idx),
        .empty_c   (empty_c),
        .last_c    (last_c),
        .match_c   (match_c)
    );

    // Decision terms shared by the next-state and output logic.
    always_comb begin
        eat_c     = (state == ST_IDLE) && food_valid && head_strobe &&
                    (head_x == food_x) && (head_y == food_y);
        start_c   = (state == ST_IDLE) && (place_req || eat_c);
        oob_c     = (rand_x > 10'(X_LIMIT)) || (rand_y > 10'(Y_LIMIT));
        reject_c  = ((state == ST_SAMPLE) && oob_c) ||
                    (((state == ST_SCAN) || (state == ST_CHECK)) && match_c);
        give_up_c = reject_c && (retry_cnt == RETRY_W'(MAX_RETRY - 1));
        commit_c  = (state == ST_CHECK) && !match_c;
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (reject_c) begin
            state_nxt = give_up_c ? ST_IDLE : ST_SAMPLE;
        end else begin
            case (state)
                ST_IDLE:   if (start_c) state_nxt = ST_SAMPLE;
                ST_SAMPLE: state_nxt = empty_c ? ST_CHECK : ST_SCAN;
                ST_SCAN:   if (last_c) state_nxt = ST_CHECK;
                ST_CHECK:  state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output and datapath next values.
    always_comb begin
        retry_nxt      = retry_cnt;
        cand_x_nxt     = cand_x;
        cand_y_nxt     = cand_y;
        food_x_nxt     = food_x;
        food_y_nxt     = food_y;
        food_valid_nxt = food_valid;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        fail_nxt       = 1'b0;
        eaten_nxt      = 1'b0;
        if (start_c) begin
            eaten_nxt      = eat_c;
            food_valid_nxt = 1'b0;
            busy_nxt       = 1'b1;
            retry_nxt      = '0;
        end
        if (state == ST_SAMPLE) begin
            cand_x_nxt = rand_x;
            cand_y_nxt = rand_y;
        end
        if (reject_c) begin
            if (give_up_c) begin
                fail_nxt = 1'b1;
                busy_nxt = 1'b0;
            end else begin
                retry_nxt = retry_cnt + RETRY_W'(1);
            end
        end
        if (commit_c) begin
            food_x_nxt     = cand_x;
            food_y_nxt     = cand_y;
            food_valid_nxt = 1'b1;
            busy_nxt       = 1'b0;
            done_nxt       = 1'b1;
        end
    end

    // Registered outputs and placement datapath.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retry_cnt  <= '0;
            cand_x     <= '0;
            cand_y     <= '0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
            busy       <= 1'b0;
            place_done <= 1'b0;
            place_fail <= 1'b0;
            eaten      <= 1'b0;
        end else begin
            retry_cnt  <= retry_nxt;
            cand_x     <= cand_x_nxt;
            cand_y     <= cand_y_nxt;
            food_x     <= food_x_nxt;
            food_y     <= food_y_nxt;
            food_valid <= food_valid_nxt;
            busy       <= busy_nxt;
            place_done <= done_nxt;
            place_fail <= fail_nxt;
            eaten      <= eaten_nxt;
        end
    end

endmodule
